// File: rtl/wb_port_scheduler_pkg.sv
// Shared definitions for the register-file write-port scheduler:
// FSM encoding, write-back requester indices and the $0 register index.
package wb_port_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SRC_RT = 3'd0;
  localparam logic [SEL_W-1:0] SRC_RD = 3'd1;
  localparam logic [SEL_W-1:0] SRC_RA = 3'd2;
  localparam logic [SEL_W-1:0] SRC_SP = 3'd3;
  localparam logic [SEL_W-1:0] SRC_RS = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_port_scheduler_rr_pick.sv
// Combinational round-robin picker: the first asserted request found
// scanning upward from i_ptr (wrapping modulo NREQ) wins.
module wb_port_scheduler_rr_pick
  import wb_port_scheduler_pkg::*;
#(
  parameter int NREQ = 5
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if ((int'(i_ptr) + k) >= NREQ) begin
        w_cand = SEL_W'(int'(i_ptr) + k - NREQ);
      end else begin
        w_cand = SEL_W'(int'(i_ptr) + k);
      end
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: serialises five register-file write requesters
// through a round-robin IDLE -> SETUP -> WRITE sequence with registered outputs.
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int NREQ = 5,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata_flat,
  input  logic [AW-1:0]      dest_idx,
  output logic [SEL_W-1:0]   src_sel,
  output logic [DW-1:0]      wr_data,
  output logic               reg_write,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               zero_drop
);

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [NREQ-1:0]  w_sel_onehot;
  logic [NREQ-1:0]  w_req_arb;
  logic             w_pick_valid;
  logic [SEL_W-1:0] w_pick_idx;
  logic [DW-1:0]    w_pick_data;
  logic             w_sel_req;
  logic             w_take;
  logic             w_commit;
  logic [SEL_W-1:0] w_ptr_next;

  assign w_sel_onehot = NREQ'(1) << r_sel;
  assign w_sel_req    = |(req & w_sel_onehot);
  assign w_ptr_next   = (r_sel == SEL_W'(NREQ - 1)) ? '0 : r_sel + SEL_W'(1);

  // The requester being written this cycle is still holding req; keep it out of the next decision.
  always_comb begin
    w_req_arb = req;
    if (r_state == WRITE) begin
      w_req_arb = req & ~w_sel_onehot;
    end
  end

  wb_port_scheduler_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req   (w_req_arb),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == SEL_W'(i)) begin
        w_pick_data = wdata_flat[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_next_state = SETUP;
          w_take       = 1'b1;
        end
      end
      SETUP: begin
        if (w_sel_req) begin
          w_next_state = WRITE;
          w_commit     = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      WRITE: begin
        if (w_pick_valid) begin
          w_next_state = SETUP;
          w_take       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // src_sel and wr_data change only on a new decision so the mux control never glitches while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_rr_ptr  <= '0;
      src_sel   <= '0;
      wr_data   <= '0;
      reg_write <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      zero_drop <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      busy      <= (w_next_state != IDLE);
      gnt       <= '0;
      reg_write <= 1'b0;
      zero_drop <= 1'b0;
      if (w_take) begin
        r_sel   <= w_pick_idx;
        src_sel <= w_pick_idx;
        wr_data <= w_pick_data;
      end
      if (w_commit) begin
        gnt       <= w_sel_onehot;
        reg_write <= (dest_idx != AW'(REG_ZERO));
        zero_drop <= (dest_idx == AW'(REG_ZERO));
        r_rr_ptr  <= w_ptr_next;
      end
    end
  end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Arbitrates the single register-file write port between five write-back requesters in the multicycle CPU.
- Requester order matches the five-input destination-index select mux: 0 = rt, 1 = rd, 2 = $ra (31), 3 = $sp (29), 4 = rs.
- Drives that mux's 3-bit control, the write data and the RegWrite strobe.
- Serializes simultaneous requests with round-robin fairness and returns a one-cycle grant to the winner.

Parameters:
- NREQ, 5, number of requesters; fixed to the five mux inputs, and 3-bit select encoding requires NREQ <= 8.
- DW, 32, register data width.
- AW, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held high until its gnt bit pulses.
- wdata_flat  in  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW], stable while req[i]=1.
- dest_idx  in  AW  destination index fed back from the select-mux output.
- src_sel  out  3  select-mux control (binary requester index).
- wr_data  out  DW  data to the register-file write port.
- reg_write  out  1  register-file write enable.
- gnt  out  NREQ  one-hot grant pulse, one cycle.
- busy  out  1  high whenever state != IDLE.
- zero_drop  out  1  one-cycle pulse when a granted write targets $0 and is suppressed.

Behaviour:
- Reset (asynchronous, reset=0) clears everything: state=IDLE, rr_ptr=0, src_sel=3'b000, wr_data=0, reg_write=0, gnt=0, busy=0, zero_drop=0. Reset mid-transaction abandons the write with no gnt. All outputs are registered.
- Arbitration: round-robin starting at rr_ptr, scanning rr_ptr, rr_ptr+1, ... mod NREQ. The first asserted req wins and is latched as sel.
- States:
  - IDLE:
    - if any req: src_sel<=sel, wr_data<=wdata[sel], then SETUP.
    - else stay in IDLE; src_sel holds its last value (no glitching of the mux control).
  - SETUP: one settle cycle so dest_idx becomes valid through the mux.
    - if req[sel]=0 (requester withdrew): abort to IDLE; no gnt; rr_ptr unchanged.
    - else go to WRITE.
  - WRITE: lasts one cycle.
    - gnt[sel]=1.
    - reg_write=1 if dest_idx!=0; otherwise reg_write=0 and zero_drop=1.
    - rr_ptr<=(sel+1) mod NREQ.
    - Next state follows the IDLE decision rule, using req masked to exclude sel. If another request is pending, go straight to SETUP with the new sel/src_sel/wr_data (back-to-back). Otherwise go to IDLE.
- Timing:
  - Latency from req rising in IDLE to gnt is 2 cycles (IDLE decision edge, then SETUP, then WRITE).
  - Sustained throughput is one write per 2 cycles.
- Requests are sampled only in IDLE, or in WRITE for the next decision. A req that arrives during SETUP waits.
- A requester must drop req in the cycle after its gnt. If req stays high, it is treated as a new request, subject to round-robin.
- Data path: wr_data is captured at the IDLE/WRITE decision edge. Changing wdata afterwards has no effect on the current write.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, SETUP=2'd1, WRITE=2'd2.
  - requester index constants: SRC_RT=0, SRC_RD=1, SRC_RA=2, SRC_SP=3, SRC_RS=4.
  - REG_ZERO=5'd0.
- One natural sub-module, rr_pick: combinational round-robin picker. Inputs req and ptr; outputs valid and a 3-bit index. It is instantiated once.
- Data selection and the FSM stay in the top module.

Test Plan:
- Reset: hold reset=0 with req=5'b11111 → all outputs 0. Release reset → first gnt=5'b00001 exactly 2 cycles later, with src_sel=0.
- Single request: req[1]=1, wdata1=32'hDEADBEEF, dest_idx=5'd8 → src_sel=1, then one cycle later reg_write=1, wr_data=32'hDEADBEEF, gnt=5'b00010.
- Round-robin: req=5'b10101 held, each requester dropping its req on grant → grant order 0, 2, 4, each 2 cycles apart, busy high throughout. Re-issuing req[0] and req[4] with rr_ptr=3 → 4 is granted before 0.
- $0 suppression: req[0]=1 with dest_idx=5'd0 → gnt=5'b00001, reg_write=0, zero_drop=1 for one cycle.
- Withdrawal: req[3] asserted, then deasserted during SETUP → no gnt, no reg_write, return to IDLE, rr_ptr still 0.
- Mid-operation reset: assert reset=0 during WRITE → reg_write and gnt fall immediately (async). After release, pending req=5'b00100 is granted normally with src_sel=2.
